// File: rtl/fpu_operand_stage.sv
// ---------------------------------------------------------------------------
// fpu_operand_stage
// Purpose: selects each FP source operand from the register file or from the
// youngest matching forwarding source, stalls issue while a matching producer
// is still busy, and holds the selected operand set in a one-entry output
// register with valid/ready handshakes on both sides.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset
//   in_valid     an issuing FP instruction is presented
//   in_ready     stage accepts the instruction this cycle (combinational)
//   in_use       per-channel: operand is read by the instruction
//   in_rs        packed source register numbers, 5 bits per channel
//   rf_data      packed register-file read data, XLEN bits per channel
//   fwd_valid    per source: completed result available for fwd_rd[j]
//   fwd_busy     per source: will write fwd_rd[j], result not ready yet
//   fwd_rd       packed destination register numbers, 5 bits per source
//   fwd_data     packed forwarded results, XLEN bits per source
//   flush        drop the held operand set
//   out_valid    operand register holds a valid set
//   out_ready    FPU consumes the held set this cycle
//   out_ops      registered selected operands, packed like rf_data
//   out_fwd_hit  registered per-channel forwarding-taken flags
//   stall_cnt    saturating count of hazard-stall cycles
// ---------------------------------------------------------------------------
module fpu_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_OPS = 3,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS-1:0]        in_use,
  input  logic [5*NUM_OPS-1:0]      in_rs,
  input  logic [XLEN*NUM_OPS-1:0]   rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_busy,
  input  logic [5*NUM_FWD-1:0]      fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0]   fwd_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN*NUM_OPS-1:0]   out_ops,
  output logic [NUM_OPS-1:0]        out_fwd_hit
  ,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned REG_W = 5;

  logic [XLEN*NUM_OPS-1:0] w_sel_ops;
  logic [NUM_OPS-1:0]      w_sel_hit;
  logic [NUM_OPS-1:0]      w_ch_hazard;
  logic [NUM_OPS-1:0]      w_matched;
  logic                    w_hazard;
  logic                    w_capture;

  logic                    r_out_valid;
  logic [XLEN*NUM_OPS-1:0] r_out_ops;
  logic [NUM_OPS-1:0]      r_out_hit;
  logic [CNT_W-1:0]        r_stall_cnt;

  // Operand selection: the first (youngest) matching source decides the
  // channel; a busy-but-not-valid winner blocks older sources and flags a hazard.
  always_comb begin
    w_sel_ops   = rf_data;
    w_sel_hit   = '0;
    w_ch_hazard = '0;
    w_matched   = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      for (int unsigned j = 0; j < NUM_FWD; j++) begin
        if (!w_matched[k] && in_use[k] && (fwd_valid[j] || fwd_busy[j]) &&
            (fwd_rd[REG_W*j +: REG_W] == in_rs[REG_W*k +: REG_W])) begin
          w_matched[k] = 1'b1;
          if (fwd_valid[j]) begin
            w_sel_ops[XLEN*k +: XLEN] = fwd_data[XLEN*j +: XLEN];
            w_sel_hit[k]              = 1'b1;
          end else begin
            w_ch_hazard[k] = 1'b1;
          end
        end
      end
    end
  end

  // Accept when hazard-free and the output slot is empty or draining now.
  assign w_hazard  = |w_ch_hazard;
  assign in_ready  = !w_hazard && (!r_out_valid || out_ready);
  assign w_capture = in_valid && in_ready;

  // Output operand register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ops   <= '0;
      r_out_hit   <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_capture) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_capture) begin
        r_out_ops <= w_sel_ops;
        r_out_hit <= w_sel_hit;
      end
    end
  end

  // Hazard-stall counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (in_valid && w_hazard && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_valid;
  assign out_ops     = r_out_ops;
  assign out_fwd_hit = r_out_hit;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_fpu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_fpu_operand_stage
// Purpose: directed-vector bench for fpu_operand_stage; expected operand sets
// are queued at issue and compared by an independent output monitor.
// ---------------------------------------------------------------------------
module tb_fpu_operand_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NUM_OPS = 3;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned CNT_W   = 4;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_OPS-1:0]      in_use;
  logic [5*NUM_OPS-1:0]    in_rs;
  logic [XLEN*NUM_OPS-1:0] rf_data;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_busy;
  logic [5*NUM_FWD-1:0]    fwd_rd;
  logic [XLEN*NUM_FWD-1:0] fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN*NUM_OPS-1:0] out_ops;
  logic [NUM_OPS-1:0]      out_fwd_hit;
  logic [CNT_W-1:0]        stall_cnt;

  typedef struct packed {
    logic [XLEN*NUM_OPS-1:0] ops;
    logic [NUM_OPS-1:0]      hit;
  } exp_t;

  exp_t sb_q[$];
  int   total;
  int   bad;
  int   pops;

  localparam logic [31:0] A = 32'hAAAA_0001;
  localparam logic [31:0] B = 32'hBBBB_0002;
  localparam logic [31:0] C = 32'hCCCC_0003;

  fpu_operand_stage #(
    .XLEN(XLEN), .NUM_OPS(NUM_OPS), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_use(in_use), .in_rs(in_rs), .rf_data(rf_data),
    .fwd_valid(fwd_valid), .fwd_busy(fwd_busy), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ops(out_ops), .out_fwd_hit(out_fwd_hit),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [14:0] rs, input logic [2:0] use_v,
                       input logic [95:0] rf, input logic [1:0] fv,
                       input logic [1:0] fb, input logic [9:0] frd,
                       input logic [63:0] fd);
    in_rs     = rs;
    in_use    = use_v;
    rf_data   = rf;
    fwd_valid = fv;
    fwd_busy  = fb;
    fwd_rd    = frd;
    fwd_data  = fd;
  endtask

  // Issue one hazard-free instruction, queue its expectation, check capture.
  task automatic issue(input string name, input logic [95:0] eops, input logic [2:0] ehit);
    exp_t e;
    in_valid = 1'b1;
    #1;
    check({name, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    e.ops = eops;
    e.hit = ehit;
    sb_q.push_back(e);
    cyc();
    in_valid = 1'b0;
    check({name, "_out_valid"}, 128'(out_valid), 128'(1'b1));
  endtask

  // Monitor: compare each consumed output set against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got ops=%h with empty queue", out_ops);
        end else begin
          e = sb_q.pop_front();
          check("mon_out_ops", 128'(out_ops), 128'(e.ops));
          check("mon_out_fwd_hit", 128'(out_fwd_hit), 128'(e.hit));
          pops++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0; pops = 0;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(15'd0, 3'b000, 96'd0, 2'b00, 2'b00, 10'd0, 64'd0);
    cyc();
    cyc();
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_out_ops", 128'(out_ops), 128'(0));
    check("rst_out_fwd_hit", 128'(out_fwd_hit), 128'(0));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    rst = 1'b0;
    cyc();

    // No forwarding match: register-file data everywhere.
    drive({5'd3, 5'd2, 5'd1}, 3'b111, {C, B, A}, 2'b00, 2'b00, 10'd0, 64'd0);
    issue("nomatch", {C, B, A}, 3'b000);
    cyc();

    // Both sources match rs1: youngest wins.
    drive({5'd10, 5'd9, 5'd5}, 3'b111, {C, B, A}, 2'b11, 2'b00,
          {5'd5, 5'd5}, {32'h4000_0000, 32'h3F80_0000});
    issue("priority", {C, B, 32'h3F80_0000}, 3'b001);
    cyc();

    // Register 0 forwards normally; valid beats busy; unused channel ignored.
    drive({5'd0, 5'd8, 5'd0}, 3'b011, {C, B, A}, 2'b11, 2'b01,
          {5'd0, 5'd8}, {32'h1234_5678, 32'h9ABC_DEF0});
    issue("reg0", {C, 32'h9ABC_DEF0, 32'h1234_5678}, 3'b011);
    cyc();

    // Busy producer for rs2: three stall cycles, then forward.
    drive({5'd2, 5'd7, 5'd1}, 3'b111, {C, B, A}, 2'b00, 2'b01,
          {5'd20, 5'd7}, 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("busy_in_ready", 128'(in_ready), 128'(1'b0));
      cyc();
    end
    check("busy_stall_cnt", 128'(stall_cnt), 128'(3));
    check("busy_no_capture", 128'(out_valid), 128'(1'b0));
    fwd_valid = 2'b01;
    fwd_data  = {32'h0, 32'h4040_0000};
    issue("busy_release", {C, 32'h4040_0000, A}, 3'b010);
    check("busy_stall_hold", 128'(stall_cnt), 128'(3));
    cyc();

    // Streaming: one capture per cycle with in_ready held high.
    drive({5'd3, 5'd2, 5'd1}, 3'b111, 96'd0, 2'b00, 2'b00, 10'd0, 64'd0);
    begin
      exp_t e;
      int   p0;
      p0 = pops;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        rf_data = {32'hC000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
        #1;
        check("stream_in_ready", 128'(in_ready), 128'(1'b1));
        e.ops = rf_data;
        e.hit = 3'b000;
        sb_q.push_back(e);
        cyc();
        check("stream_out_valid", 128'(out_valid), 128'(1'b1));
      end
      in_valid = 1'b0;
      cyc();
      check("stream_pops", 128'(pops - p0), 128'(8));
    end
    cyc();

    // Backpressure: held set stays stable, then flush drops it.
    out_ready = 1'b0;
    drive({5'd3, 5'd2, 5'd1}, 3'b111, {32'hE3, 32'hE2, 32'hE1}, 2'b00, 2'b00, 10'd0, 64'd0);
    issue("bp_load", {32'hE3, 32'hE2, 32'hE1}, 3'b000);
    rf_data  = {32'hF3, 32'hF2, 32'hF1};
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_in_ready", 128'(in_ready), 128'(1'b0));
      check("bp_out_ops", 128'(out_ops), 128'({32'hE3, 32'hE2, 32'hE1}));
      check("bp_out_valid", 128'(out_valid), 128'(1'b1));
      cyc();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    void'(sb_q.pop_front());
    cyc();
    check("flush_out_valid", 128'(out_valid), 128'(1'b0));
    // Flush wins over a capture in the same cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check("flush_cap_in_ready", 128'(in_ready), 128'(1'b1));
    cyc();
    check("flush_cap_out_valid", 128'(out_valid), 128'(1'b0));
    check("flush_stall_cnt", 128'(stall_cnt), 128'(3));
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();

    // Saturating stall counter.
    drive({5'd2, 5'd7, 5'd1}, 3'b111, {C, B, A}, 2'b00, 2'b01, {5'd20, 5'd7}, 64'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("sat_mid", 128'(stall_cnt), 128'(8));
    for (int i = 0; i < 15; i++) cyc();
    check("sat_final", 128'(stall_cnt), 128'(15));
    in_valid = 1'b0;
    cyc();

    // Reset discards a held set and clears all outputs.
    out_ready = 1'b0;
    drive({5'd3, 5'd2, 5'd1}, 3'b111, {C, B, A}, 2'b01, 2'b00, {5'd20, 5'd1}, {32'h0, 32'h55});
    issue("rst_load", {C, B, 32'h55}, 3'b001);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    void'(sb_q.pop_front());
    check("rst2_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst2_out_ops", 128'(out_ops), 128'(0));
    check("rst2_out_fwd_hit", 128'(out_fwd_hit), 128'(0));
    check("rst2_stall_cnt", 128'(stall_cnt), 128'(0));
    out_ready = 1'b1;
    drive({5'd3, 5'd2, 5'd1}, 3'b111, {C, B, A}, 2'b00, 2'b00, 10'd0, 64'd0);
    issue("post_rst", {C, B, A}, 3'b000);
    cyc();
    cyc();

    check("queue_empty", 128'(sb_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
